// File: rtl/acc_pkg.sv
// Shared types for the length-programmed reduction engine and its accumulator.
package acc_pkg;

    localparam int LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

endpackage

// File: rtl/acc.sv
// Signed accumulator: on en, loads (init) or adds the sign-extended sample; wraps modulo 2^D_W_ACC.
module acc #(
    parameter int D_W     = 32,
    parameter int D_W_ACC = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      init,
    input  logic signed [D_W-1:0]     in_data,
    output logic signed [D_W_ACC-1:0] result
);

    logic signed [D_W_ACC-1:0] in_ext;
    logic signed [D_W_ACC-1:0] sum_d;
    logic signed [D_W_ACC-1:0] sum_q;

    always_comb begin
        in_ext = D_W_ACC'(in_data);
        sum_d  = sum_q;
        if (en) begin
            sum_d = init ? in_ext : sum_q + in_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign result = sum_q;

endmodule

// File: rtl/acc_reduce_ctrl.sv
// Reduction sequencer: counts cfg_len samples into one acc instance and presents the sum on a valid/ready port.
module acc_reduce_ctrl
    import acc_pkg::*;
#(
    parameter int D_W     = 32,
    parameter int D_W_ACC = 32,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          cfg_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [D_W-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_W_ACC-1:0] out_data
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               acc_en;
    logic               acc_init;
    logic               acc_zero;
    logic signed [D_W_ACC-1:0] acc_in;
    logic signed [D_W_ACC-1:0] acc_result;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_en   = 1'b0;
        acc_init = 1'b0;
        acc_zero = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        // Empty job: load a zero so the result port reads 0.
                        acc_en   = 1'b1;
                        acc_init = 1'b1;
                        acc_zero = 1'b1;
                        state_d  = OUT;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_en   = 1'b1;
                    acc_init = (cnt_q == '0);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        acc_in = acc_zero ? '0 : D_W_ACC'(in_data);
    end

    acc #(
        .D_W     (D_W_ACC),
        .D_W_ACC (D_W_ACC)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .en      (acc_en),
        .init    (acc_init),
        .in_data (acc_in),
        .result  (acc_result)
    );

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_result;

endmodule

// File: tb/tb_acc_reduce_ctrl.sv
// Bench for acc_reduce_ctrl: directed scenarios plus randomized jobs against a queue-and-sum reference.
module tb_acc_reduce_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        cfg_len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;

    logic               b_start;
    logic [15:0]        b_len;
    logic               b_busy;
    logic               b_valid;
    logic               b_ready_in;
    logic signed [7:0]  b_data;
    logic               b_out_valid;
    logic               b_out_ready;
    logic signed [31:0] b_out_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    acc_reduce_ctrl #(.D_W(32), .D_W_ACC(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    acc_reduce_ctrl #(.D_W(8), .D_W_ACC(32), .LEN_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(b_start), .cfg_len(b_len), .busy(b_busy),
        .in_valid(b_valid), .in_ready(b_ready_in), .in_data(b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        start   = 1'b1;
        cfg_len = 16'(len);
        tick();
        start   = 1'b0;
        cfg_len = 16'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) chk("beat_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic take_result(input string tag, input logic [31:0] exp, input int hold, input bit start_in_out);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_data"}, out_data, exp);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, out_data, exp);
            chk({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        if (start_in_out) begin
            start   = 1'b1;
            cfg_len = 16'd7;
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_valid_done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int          len;
        logic [31:0] sum;

        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_start = 1'b0; b_len = '0; b_valid = 1'b0; b_data = '0; b_out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // Basic job: 1+2+3+4
        start_job(4);
        send_beat(32'd1, 0);
        send_beat(32'd2, 0);
        send_beat(32'd3, 0);
        chk("basic_in_ready_mid", 32'(in_ready), 32'd1);
        send_beat(32'd4, 0);
        take_result("basic", 32'd10, 0, 1'b0);

        // Gaps and backpressure
        start_job(3);
        send_beat(-32'sd5, 2);
        send_beat(32'd7, 2);
        send_beat(32'd100, 2);
        take_result("gaps", 32'd102, 5, 1'b0);

        // Back-to-back jobs with a start attempt during OUT
        start_job(2);
        send_beat(32'd1000, 0);
        send_beat(32'd1000, 0);
        take_result("jobA", 32'd2000, 1, 1'b1);
        start_job(2);
        send_beat(32'd1, 0);
        send_beat(32'd2, 0);
        take_result("jobB", 32'd3, 0, 1'b0);

        // Zero length and signed wrap
        start_job(0);
        take_result("zero_len", 32'd0, 0, 1'b0);
        start_job(2);
        send_beat(32'h7FFF_FFFF, 0);
        send_beat(32'd1, 0);
        take_result("wrap", 32'h8000_0000, 0, 1'b0);

        // Reset mid-job, then a fresh single-beat job
        start_job(5);
        send_beat(32'd11, 0);
        send_beat(32'd22, 0);
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();
        start_job(1);
        send_beat(32'd9, 0);
        take_result("after_rst", 32'd9, 0, 1'b0);

        // Start pulsed during ACCUM is ignored
        start_job(3);
        send_beat(32'd5, 0);
        start   = 1'b1;
        cfg_len = 16'd7;
        send_beat(32'd6, 0);
        start   = 1'b0;
        send_beat(32'd7, 0);
        take_result("ign_start", 32'd18, 0, 1'b0);

        // Randomized jobs against the reference sum
        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(0, 6);
            q.delete();
            for (int k = 0; k < len; k++) q.push_back($urandom);
            sum = 32'd0;
            foreach (q[k]) sum = sum + q[k];
            start_job(len);
            foreach (q[k]) send_beat(q[k], $urandom_range(0, 2));
            take_result("rand", sum, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Narrow-input instance: 0xFF + 0xFF sign-extends to -2
        b_start = 1'b1;
        b_len   = 16'd2;
        tick();
        b_start = 1'b0;
        chk("n8_in_ready", 32'(b_ready_in), 32'd1);
        b_valid = 1'b1;
        b_data  = 8'hFF;
        tick();
        tick();
        b_valid = 1'b0;
        chk("n8_valid", 32'(b_out_valid), 32'd1);
        chk("n8_data", b_out_data, 32'hFFFF_FFFE);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("n8_busy_done", 32'(b_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
